trace_commit_arbiter: RTL and testbench
=======================================

// Module: trace_commit_arbiter
// PURPOSE
//  Collects completed trace_output records from two unhandshaked producers.
//  - Source 0: WB tracker record output.
//  - Source 1: pass-through / auxiliary tracker record output.
//  Arbitrates them round-robin into one FIFO and drains it to the trace sink over valid/ready.
//  Sits between the per-stage trackers and the trace buffer; owns ordering, sequencing and overflow accounting.
// PARAMETERS
//  FIFO_DEPTH  8   record FIFO entries; power of two, >= 2
//  SEQ_WIDTH   16  width of per-record sequence tag
// PORTS
//  clk          in   1                 single clock, all logic on posedge
//  rst_n        in   1                 asynchronous reset, active-low
//  trace_en     in   1                 0: source valids ignored; FIFO still drains
//  src0_valid   in   1                 1-cycle pulse, src0_data valid
//  src0_data    in   trace_output      record from WB tracker
//  src1_valid   in   1                 1-cycle pulse, src1_data valid
//  src1_data    in   trace_output      record from auxiliary source
//  out_valid    out  1                 head record available
//  out_ready    in   1                 sink accepts when out_valid & out_ready
//  out_data     out  trace_output      head record
//  out_src      out  1                 source id of head record
//  out_seq      out  SEQ_WIDTH         sequence tag of head record
//  overflow     out  1                 sticky; set on any dropped record
//  drop_count   out  16                dropped-record count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: FIFO empty; both slots empty; rr_last=1 (src0 wins first); seq=0.
//    Outputs at reset: out_valid=0, out_data='0, out_src=0, out_seq=0, overflow=0, drop_count=0.
//    Reset mid-operation discards all held and queued records.
//  - Capture: per source, one holding slot.
//    srcN_valid & trace_en captures srcN_data into slotN at the edge.
//    Capture into a full slot is allowed only if that slot is granted in the same cycle.
//    Otherwise the new record is dropped, overflow is set, and the old slot contents are kept.
//  - Arbiter: 2-state FSM on rr_last (LAST_SRC0, LAST_SRC1).
//    Each cycle, grant at most one full slot when the FIFO can accept.
//    Both slots full: grant the source != rr_last. Only one full: grant it.
//    rr_last updates only on a grant.
//  - FIFO accepts when count<FIFO_DEPTH, or when count==FIFO_DEPTH and a pop occurs in the same cycle.
//  - Enqueue: entry = {data, src, seq}; seq increments by 1 per enqueue and wraps modulo 2^SEQ_WIDTH.
//  - Dequeue: out_valid = (count!=0). out_data/out_src/out_seq are combinational from the head entry.
//    Pop on out_valid & out_ready. Head holds stable while out_valid & !out_ready.
//  - Count: push without pop +1; pop without push -1; both, unchanged.
//    Pointers wrap at FIFO_DEPTH.
//  - Latency: valid in cycle N -> slot at edge N -> FIFO at edge N+1 -> out_valid in cycle N+2 (empty, idle).
//  - trace_en=0: no captures; already-held slots still arbitrate and drain.
// CONFIGURATION
//  TRACE_DROP_COUNT_EN defined:
//    - drop_count increments once per dropped record and saturates at 16'hFFFF.
//    - Two drops in one cycle add 2, with the same saturation.
//  TRACE_DROP_COUNT_EN undefined:
//    - drop_count tied to 0, no counter logic.
//    - overflow still present.
// STRUCTURE
//  - Shared package ryuki_datatypes holds:
//    - trace_output;
//    - new typedef trace_fifo_entry_t {trace_output data; logic src; logic [SEQ_WIDTH-1:0] seq};
//    - arbiter state enum.
//  - Sub-module trace_fifo: synchronous circular buffer, parameterised on FIFO_DEPTH.
//    Holds the push/pop/count logic and the combinational head read.
//  - Top level holds the slots, arbiter FSM, seq counter, overflow and drop counter.
// TESTING
//  1. Single src0 pulse, out_ready=1 -> out_valid in cycle N+2, out_src=0, out_seq=0, popped after 1 cycle.
//  2. src0 and src1 pulsed in the same cycle, FIFO empty -> out order src0 (seq 0), then src1 (seq 1).
//     Repeat -> src0 wins again (alternation follows rr_last).
//  3. out_ready=0, 12 alternating pulses, FIFO_DEPTH=8:
//     -> 8 queued, 2 held in slots, 2 dropped; overflow=1; drop_count=2 (0 without the macro).
//  4. Full FIFO, out_ready=1, src0 pulse -> push and pop in the same cycle; count stays 8; nothing dropped.
//  5. SEQ_WIDTH=4, 20 records -> out_seq sequence 0..15, 0..3, no gaps.
//  6. rst_n asserted mid-burst with 5 queued -> out_valid=0 immediately (async).
//     After release the next record has out_seq=0.

Source files
------------

// File: rtl/ryuki_datatypes_pkg.sv
// Shared trace datatypes: record payload, FIFO entry and arbiter state.
// Optional feature macro used by trace_commit_arbiter: TRACE_DROP_COUNT_EN.
package ryuki_datatypes;

  // Widest sequence tag a FIFO entry can carry; SEQ_WIDTH of the arbiter must not exceed it.
  localparam int unsigned TRACE_SEQ_W_MAX = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [7:0]  info;
  } trace_output;

  typedef struct packed {
    trace_output                 data;
    logic                        src;
    logic [TRACE_SEQ_W_MAX-1:0]  seq;
  } trace_fifo_entry_t;

  typedef enum logic {
    LAST_SRC0 = 1'b0,
    LAST_SRC1 = 1'b1
  } arb_state_t;

endpackage

// File: rtl/trace_commit_arbiter_fifo.sv
// trace_fifo: synchronous circular record buffer with combinational head read.
module trace_fifo
  import ryuki_datatypes::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  trace_fifo_entry_t              push_entry,
  input  logic                           pop,
  output trace_fifo_entry_t              head,
  output logic [$clog2(FIFO_DEPTH):0]    count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  trace_fifo_entry_t mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Storage array; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointers and occupancy; power-of-two depth makes pointer wrap free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/trace_commit_arbiter.sv
// trace_commit_arbiter: round-robin merge of two unhandshaked trace sources
// into one sequenced record FIFO drained over valid/ready.
// Optional feature: define TRACE_DROP_COUNT_EN for a saturating drop counter.
module trace_commit_arbiter
  import ryuki_datatypes::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned SEQ_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 trace_en,
  input  logic                 src0_valid,
  input  trace_output          src0_data,
  input  logic                 src1_valid,
  input  trace_output          src1_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output trace_output          out_data,
  output logic                 out_src,
  output logic [SEQ_WIDTH-1:0] out_seq,
  output logic                 overflow,
  output logic [15:0]          drop_count
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  arb_state_t        rr_last;
  arb_state_t        rr_next_c;
  logic [1:0]        grant_c;
  logic [1:0]        slot_full;
  trace_output       slot_data [2];
  trace_output       src_data_c [2];
  logic [1:0]        cap_c;
  logic [1:0]        load_c;
  logic [1:0]        drop_c;
  logic              pop_c;
  logic              push_c;
  logic              accept_c;
  logic [SEQ_WIDTH-1:0] seq;
  trace_fifo_entry_t push_entry_c;
  trace_fifo_entry_t head_c;
  logic [CNT_W-1:0]  count_c;

  assign src_data_c[0] = src0_data;
  assign src_data_c[1] = src1_data;

  // Capture qualification: load into an empty slot or one being granted away, else drop.
  assign cap_c  = {src1_valid & trace_en, src0_valid & trace_en};
  assign load_c = cap_c & (~slot_full | grant_c);
  assign drop_c = cap_c & slot_full & ~grant_c;

  // FIFO handshake: a full FIFO still accepts when its head leaves this cycle.
  assign pop_c    = out_valid & out_ready;
  assign accept_c = (count_c < CNT_W'(FIFO_DEPTH)) | pop_c;
  assign push_c   = |grant_c;

  // Round-robin state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last <= LAST_SRC1;
    end else begin
      rr_last <= rr_next_c;
    end
  end

  // Grant selection and next round-robin state; rr_last moves only on a grant.
  always_comb begin
    rr_next_c = rr_last;
    grant_c   = 2'b00;
    if (accept_c) begin
      case (slot_full)
        2'b11:   grant_c = (rr_last == LAST_SRC0) ? 2'b10 : 2'b01;
        2'b01:   grant_c = 2'b01;
        2'b10:   grant_c = 2'b10;
        default: grant_c = 2'b00;
      endcase
    end
    if (grant_c[0]) begin
      rr_next_c = LAST_SRC0;
    end else if (grant_c[1]) begin
      rr_next_c = LAST_SRC1;
    end
  end

  // Entry built from the granted slot and the current sequence tag.
  always_comb begin
    push_entry_c      = '0;
    push_entry_c.data = grant_c[1] ? slot_data[1] : slot_data[0];
    push_entry_c.src  = grant_c[1];
    push_entry_c.seq  = TRACE_SEQ_W_MAX'(seq);
  end

  // Per-source holding slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_full    <= 2'b00;
      slot_data[0] <= '0;
      slot_data[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (load_c[i]) begin
          slot_data[i] <= src_data_c[i];
          slot_full[i] <= 1'b1;
        end else if (grant_c[i]) begin
          slot_full[i] <= 1'b0;
        end
      end
    end
  end

  // Sequence tag, advanced once per enqueue and wrapping naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq <= '0;
    end else if (push_c) begin
      seq <= seq + SEQ_WIDTH'(1);
    end
  end

  // Sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (|drop_c) begin
      overflow <= 1'b1;
    end
  end

`ifdef TRACE_DROP_COUNT_EN
  logic [16:0] drop_sum_c;

  assign drop_sum_c = 17'(drop_count) + 17'(drop_c[0]) + 17'(drop_c[1]);

  // Saturating dropped-record counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (drop_sum_c[16]) begin
      drop_count <= 16'hFFFF;
    end else begin
      drop_count <= drop_sum_c[15:0];
    end
  end
`else
  assign drop_count = '0;
`endif

  trace_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_c),
    .push_entry (push_entry_c),
    .pop        (pop_c),
    .head       (head_c),
    .count      (count_c)
  );

  // Head presentation; fields read as zero while the FIFO is empty.
  assign out_valid = (count_c != '0);
  assign out_data  = out_valid ? head_c.data : '0;
  assign out_src   = out_valid ? head_c.src  : 1'b0;
  assign out_seq   = out_valid ? head_c.seq[SEQ_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_trace_commit_arbiter.sv
// Bench for trace_commit_arbiter: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_trace_commit_arbiter;
  import ryuki_datatypes::*;

  localparam int DEPTH = 8;
  localparam int SW    = 4;
  localparam int SEQ_MOD = 1 << SW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          trace_en = 1'b0;
  logic          src0_valid = 1'b0;
  logic          src1_valid = 1'b0;
  logic          out_ready = 1'b0;
  trace_output   src0_data = '0;
  trace_output   src1_data = '0;
  trace_output   out_data;
  logic          out_valid;
  logic          out_src;
  logic [SW-1:0] out_seq;
  logic          overflow;
  logic [15:0]   drop_count;

  int checks = 0;
  int errors = 0;

  trace_commit_arbiter #(
    .FIFO_DEPTH (DEPTH),
    .SEQ_WIDTH  (SW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .trace_en   (trace_en),
    .src0_valid (src0_valid),
    .src0_data  (src0_data),
    .src1_valid (src1_valid),
    .src1_data  (src1_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_seq    (out_seq),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    trace_output data;
    int          src;
    int          seq;
  } rec_t;

  rec_t        mq[$];
  bit          m_full [2];
  trace_output m_slot [2];
  int          m_last;
  int          m_seq;
  bit          m_ovf;
  int          m_drops;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_full[0] = 0; m_full[1] = 0;
      m_last = 1; m_seq = 0; m_ovf = 0; m_drops = 0;
    end else begin
      bit          pop, room;
      int          g;
      bit          v [2];
      trace_output d [2];
      rec_t        r;
      v[0] = src0_valid && trace_en;
      v[1] = src1_valid && trace_en;
      d[0] = src0_data;
      d[1] = src1_data;
      pop  = (mq.size() != 0) && out_ready;
      room = (mq.size() < DEPTH) || pop;
      g = -1;
      if (room) begin
        if (m_full[0] && m_full[1]) g = 1 - m_last;
        else if (m_full[0])         g = 0;
        else if (m_full[1])         g = 1;
      end
      if (pop) void'(mq.pop_front());
      if (g >= 0) begin
        r.data = m_slot[g]; r.src = g; r.seq = m_seq;
        mq.push_back(r);
        m_seq  = (m_seq + 1) % SEQ_MOD;
        m_last = g;
        m_full[g] = 0;
      end
      for (int i = 0; i < 2; i++) begin
        if (v[i]) begin
          if (m_full[i]) begin
            m_ovf = 1;
            if (m_drops < 65535) m_drops++;
          end else begin
            m_full[i] = 1;
            m_slot[i] = d[i];
          end
        end
      end
    end
  end

  function automatic int exp_drops();
`ifdef TRACE_DROP_COUNT_EN
    return m_drops;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_data(input string name, input trace_output act, input trace_output exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cmp_out_valid", longint'(out_valid), longint'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk_data("cmp_out_data", out_data, mq[0].data);
        chk("cmp_out_src", longint'(out_src), longint'(mq[0].src));
        chk("cmp_out_seq", longint'(out_seq), longint'(mq[0].seq));
      end else begin
        chk_data("cmp_idle_data", out_data, '0);
        chk("cmp_idle_src", longint'(out_src), 0);
        chk("cmp_idle_seq", longint'(out_seq), 0);
      end
      chk("cmp_overflow", longint'(overflow), longint'(m_ovf));
      chk("cmp_drop_count", longint'(drop_count), longint'(exp_drops()));
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic trace_output rnd_rec();
    trace_output t;
    t = {$urandom(), $urandom(), 8'($urandom())};
    return t;
  endfunction

  task automatic step(input bit v0, input bit v1, input bit rdy, input bit en);
    @(negedge clk);
    src0_valid = v0;
    src1_valid = v1;
    out_ready  = rdy;
    trace_en   = en;
    src0_data  = rnd_rec();
    src1_data  = rnd_rec();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    src0_valid = 1'b0;
    src1_valid = 1'b0;
    out_ready  = 1'b0;
    trace_en   = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int got[$];

    // Reset state
    #1;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_seq", longint'(out_seq), 0);
    chk("rst_overflow", longint'(overflow), 0);
    chk("rst_drop_count", longint'(drop_count), 0);
    do_reset();

    // Single src0 pulse: visible two cycles later, gone one cycle after that
    step(1, 0, 1, 1); chk("t1_cyc_n", longint'(out_valid), 0);
    step(0, 0, 1, 1); chk("t1_cyc_n1", longint'(out_valid), 0);
    step(0, 0, 1, 1);
    chk("t1_valid", longint'(out_valid), 1);
    chk("t1_src", longint'(out_src), 0);
    chk("t1_seq", longint'(out_seq), 0);
    step(0, 0, 1, 1); chk("t1_popped", longint'(out_valid), 0);

    // Simultaneous pulses: src0 then src1, twice
    do_reset();
    for (int k = 0; k < 2; k++) begin
      step(1, 1, 1, 1);
      if (k == 1) chk("t2_gap", longint'(out_valid), 0);
      step(0, 0, 1, 1);
      step(0, 0, 1, 1);
      chk("t2_first_src", longint'(out_src), 0);
      chk("t2_first_seq", longint'(out_seq), 2 * k);
      step(0, 0, 1, 1);
      chk("t2_second_src", longint'(out_src), 1);
      chk("t2_second_seq", longint'(out_seq), 2 * k + 1);
    end

    // Blocked sink, 12 alternating pulses: 8 queued, 2 held, 2 dropped
    do_reset();
    for (int i = 0; i < 12; i++) step(i % 2 == 0, i % 2 == 1, 0, 1);
    repeat (3) step(0, 0, 0, 1);
    chk("t3_overflow", longint'(overflow), 1);
`ifdef TRACE_DROP_COUNT_EN
    chk("t3_drop_count", longint'(drop_count), 2);
`else
    chk("t3_drop_count", longint'(drop_count), 0);
`endif
    n = 0;
    repeat (20) begin
      step(0, 0, 1, 1);
      if (out_valid) n++;
    end
    chk("t3_records_out", n, 10);

    // Full FIFO: push and pop in the same cycle, nothing lost
    do_reset();
    for (int i = 0; i < 8; i++) step(i % 2 == 0, i % 2 == 1, 0, 1);
    repeat (3) step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    step(0, 0, 1, 1);
    n = 0;
    repeat (12) begin
      step(0, 0, 1, 1);
      if (out_valid) n++;
    end
    chk("t4_records_after", n, 8);
    chk("t4_overflow", longint'(overflow), 0);
    chk("t4_drop_count", longint'(drop_count), 0);

    // 20 records with a 4-bit tag: 0..15 then 0..3
    do_reset();
    got.delete();
    for (int i = 0; i < 26; i++) begin
      step(i < 20, 0, 1, 1);
      if (out_valid) got.push_back(int'(out_seq));
    end
    chk("t5_count", got.size(), 20);
    for (int i = 0; i < got.size(); i++) chk("t5_seq", got[i], i % 16);

    // trace_en low: pulses ignored
    do_reset();
    repeat (4) step(1, 1, 1, 0);
    step(0, 0, 1, 1); step(0, 0, 1, 1);
    chk("t_en_idle", longint'(out_valid), 0);

    // Async reset mid-burst with 5 queued
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1);
    repeat (3) step(0, 0, 0, 1);
    chk("t6_pre_valid", longint'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", longint'(out_valid), 0);
    chk("t6_async_seq", longint'(out_seq), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 1, 1);
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    chk("t6_post_valid", longint'(out_valid), 1);
    chk("t6_post_src", longint'(out_src), 1);
    chk("t6_post_seq", longint'(out_seq), 0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(99) < 45, $urandom_range(99) < 45,
           $urandom_range(99) < 60, $urandom_range(9) != 0);
    end
    repeat (20) step(0, 0, 1, 1);
    chk("rand_drained", longint'(out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
